// File: rtl/pixel_unpacker_if.sv
`default_nettype none
// ============================================================================
// pixel_unpacker_if : packed-RGB AXI-Stream input plus unpacked pixel output
// Revision 1.0
// ============================================================================
interface pixel_unpacker_if;
    logic [31:0] in_stream_tdata;
    logic [3:0]  in_stream_tkeep;
    logic        in_stream_tlast;
    logic        in_stream_tuser;
    logic        in_stream_tvalid;
    logic        in_stream_tready;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_valid;
    logic        pix_ready;
    logic        err_clear;
    logic        line_err;
    logic        sof_err;
    logic [15:0] frame_count;

    modport slave (
        input  in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser,
        input  in_stream_tvalid, pix_ready, err_clear,
        output in_stream_tready, r, g, b, pix_sof, pix_eol, pix_valid,
        output line_err, sof_err, frame_count
    );

    modport master (
        output in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser,
        output in_stream_tvalid, pix_ready, err_clear,
        input  in_stream_tready, r, g, b, pix_sof, pix_eol, pix_valid,
        input  line_err, sof_err, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/pixel_unpacker.sv
`default_nettype none
// ============================================================================
// pixel_unpacker : 3x32-bit words -> 4x24-bit RGB pixels, with X/Y framing checks
// Revision 1.0
// ============================================================================
module pixel_unpacker #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  wire logic       in_stream_aclk,
    input  wire logic       periph_resetn,
    pixel_unpacker_if.slave bus
);
    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [XW-1:0] X_PEN  = XW'(X_SIZE - 2);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    typedef enum logic [1:0] {P0 = 2'd0, P1 = 2'd1, P2 = 2'd2, P3 = 2'd3} phase_t;

    phase_t        phase_q, phase_d;
    logic [23:0]   res_q, res_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [15:0]   frame_q, frame_d;
    logic          sof_q, sof_d, eol_q, eol_d, valid_q, valid_d;
    logic          eol_pend_q, eol_pend_d;
    logic          line_err_q, line_err_d, sof_err_q, sof_err_d;
    logic          run_q;

    logic          out_free, tready, accept, load;
    logic          line_end, set_line, set_sof;
    logic [23:0]   pix;
    logic [31:0]   w;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          unused_tkeep;

    assign unused_tkeep = ^bus.in_stream_tkeep;

    // run_q keeps tready low while reset is held and for the release cycle
    assign out_free = !valid_q || bus.pix_ready;
    assign tready   = run_q && out_free && (phase_q != P3);
    assign accept   = bus.in_stream_tvalid && tready;
    assign w        = bus.in_stream_tdata;

    always_comb begin
        phase_d    = phase_q;
        res_d      = res_q;
        rgb_d      = rgb_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        valid_d    = valid_q && !bus.pix_ready;
        x_d        = x_q;
        y_d        = y_q;
        frame_d    = frame_q;
        eol_pend_d = eol_pend_q;
        load       = 1'b0;
        pix        = res_q;
        pos_x      = x_q;
        pos_y      = y_q;
        line_end   = 1'b0;
        set_line   = 1'b0;
        set_sof    = 1'b0;

        if (accept) begin
            load = 1'b1;
            // A tuser word is always decoded as W0 and restarts the frame at (0,0)
            if (bus.in_stream_tuser || phase_q == P0) begin
                pix     = w[23:0];
                res_d   = {16'h0, w[31:24]};
                phase_d = P1;
                if (bus.in_stream_tuser) begin
                    pos_x   = '0;
                    pos_y   = '0;
                    set_sof = (phase_q != P0) || (x_q != '0) || (y_q != '0);
                end
                if (bus.in_stream_tlast) begin
                    phase_d  = P0;
                    line_end = 1'b1;
                    set_line = 1'b1;
                end
            end else if (phase_q == P1) begin
                pix     = {w[15:0], res_q[7:0]};
                res_d   = {8'h0, w[31:16]};
                phase_d = P2;
                if (bus.in_stream_tlast) begin
                    phase_d  = P0;
                    line_end = 1'b1;
                    set_line = 1'b1;
                end
            end else begin
                pix        = {w[7:0], res_q[15:0]};
                res_d      = w[31:8];
                phase_d    = P3;
                set_line   = bus.in_stream_tlast != (x_q == X_PEN);
                eol_pend_d = bus.in_stream_tlast && (x_q != X_PEN);
            end
        end else if (phase_q == P3 && out_free) begin
            // Misplaced tlast on the P2 word ends the line after p3 is emitted
            load       = 1'b1;
            phase_d    = P0;
            line_end   = eol_pend_q;
            eol_pend_d = 1'b0;
        end

        if (load) begin
            valid_d = 1'b1;
            rgb_d   = pix;
            sof_d   = (pos_x == '0) && (pos_y == '0);
            eol_d   = (pos_x == X_LAST);
            if (line_end || pos_x == X_LAST) begin
                x_d = '0;
                if (pos_y == Y_LAST) begin
                    y_d     = '0;
                    frame_d = frame_q + 16'd1;
                end else begin
                    y_d = pos_y + 1'b1;
                end
            end else begin
                x_d = pos_x + 1'b1;
                y_d = pos_y;
            end
        end

        line_err_d = !bus.err_clear && (line_err_q || set_line);
        sof_err_d  = !bus.err_clear && (sof_err_q || set_sof);
    end

    always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            phase_q    <= P0;
            res_q      <= '0;
            rgb_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            valid_q    <= 1'b0;
            eol_pend_q <= 1'b0;
            line_err_q <= 1'b0;
            sof_err_q  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            res_q      <= res_d;
            rgb_q      <= rgb_d;
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            valid_q    <= valid_d;
            eol_pend_q <= eol_pend_d;
            line_err_q <= line_err_d;
            sof_err_q  <= sof_err_d;
            run_q      <= 1'b1;
        end
    end

    assign bus.in_stream_tready = tready;
    assign bus.r                = rgb_q[23:16];
    assign bus.g                = rgb_q[15:8];
    assign bus.b                = rgb_q[7:0];
    assign bus.pix_sof          = sof_q;
    assign bus.pix_eol          = eol_q;
    assign bus.pix_valid        = valid_q;
    assign bus.line_err         = line_err_q;
    assign bus.sof_err          = sof_err_q;
    assign bus.frame_count      = frame_q;
endmodule
`default_nettype wire
